// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared state and opcode encodings for the multi-precision ALU.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/unit_sum.sv
// ============================================================================
// Module  : unit_sum
// Brief   : Dual-path word adder: a+b and a+b+1 computed side by side.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module unit_sum #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum0,
    output logic             cout0,
    output logic [WIDTH-1:0] sum1,
    output logic             cout1
);

    always_comb begin
        {cout0, sum0} = {1'b0, a} + {1'b0, b};
        {cout1, sum1} = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(1);
    end

endmodule

`default_nettype wire

// File: rtl/mp_add_seq.sv
// ============================================================================
// Module  : mp_add_seq
// Brief   : Word-serial multi-precision add/subtract with valid/ready streams.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module mp_add_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NWORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_sub,
    input  logic             cmd_cin,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             cout,
    output logic             ovf
);

    localparam int              IDXW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [IDXW-1:0]   r_idx;
    logic              r_cy;
    logic              r_sub;

    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_is_last;
    logic [WIDTH-1:0]  w_b_eff;
    logic [WIDTH-1:0]  w_sum0;
    logic [WIDTH-1:0]  w_sum1;
    logic [WIDTH-1:0]  w_sum_sel;
    logic              w_cout0;
    logic              w_cout1;
    logic              w_next_cy;

    assign cmd_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign in_ready   = (r_state == ST_RUN) && (!out_valid || out_ready);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_is_last  = (r_idx == LAST_IDX);

    // Subtraction is A + ~B + 1; the +1 enters through the initial carry.
    assign w_b_eff = (r_sub == OP_SUB) ? ~in_b : in_b;

    unit_sum #(.WIDTH(WIDTH)) u_unit_sum (
        .a     (in_a),
        .b     (w_b_eff),
        .sum0  (w_sum0),
        .cout0 (w_cout0),
        .sum1  (w_sum1),
        .cout1 (w_cout1)
    );

    assign w_sum_sel = r_cy ? w_sum1  : w_sum0;
    assign w_next_cy = r_cy ? w_cout1 : w_cout0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (cmd_valid)              w_state_next = ST_RUN;
            ST_RUN:   if (w_in_fire && w_is_last) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_out_fire)             w_state_next = ST_IDLE;
            default:                              w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= '0;
            r_cy      <= 1'b0;
            r_sub     <= OP_ADD;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_sub <= cmd_sub ? OP_SUB : OP_ADD;
                        r_cy  <= cmd_sub ? ~cmd_cin : cmd_cin;
                        r_idx <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_in_fire) begin
                        out_sum   <= w_sum_sel;
                        r_cy      <= w_next_cy;
                        out_valid <= 1'b1;
                        out_last  <= w_is_last;
                        if (w_is_last) begin
                            cout <= (r_sub == OP_SUB) ? ~w_next_cy : w_next_cy;
                            ovf  <= (in_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                                    (w_sum_sel[WIDTH-1] != in_a[WIDTH-1]);
                        end else begin
                            r_idx <= r_idx + IDXW'(1);
                        end
                    end else if (w_out_fire) begin
                        out_valid <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (w_out_fire) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
